// File: rtl/fifo_1_if.sv
// Handshake/data bundle between a producer/consumer and the fifo_1 buffer.
// FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow status signals.
interface fifo_1_if #(
  parameter int unsigned data_width = 32
);
  logic                  cs;
  logic                  wr_en;
  logic                  rd_en;
  logic [data_width-1:0] data_in;
  logic [data_width-1:0] data_out;
  logic                  empty;
  logic                  full;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (
    output cs, wr_en, rd_en, data_in,
    input  data_out, empty, full, overflow, underflow
  );
  modport slave (
    input  cs, wr_en, rd_en, data_in,
    output data_out, empty, full, overflow, underflow
  );
`else
  modport master (
    output cs, wr_en, rd_en, data_in,
    input  data_out, empty, full
  );
  modport slave (
    input  cs, wr_en, rd_en, data_in,
    output data_out, empty, full
  );
`endif
endinterface

// File: rtl/fifo_1.sv
// Single-clock synchronous FIFO with registered read data and chip select.
// Optional sticky overflow/underflow flags are enabled by FIFO_ERR_FLAGS_EN.
module fifo_1 #(
  parameter int unsigned fifo_depth = 8,
  parameter int unsigned data_width = 32
) (
  input logic      clk,
  input logic      rst_n,
  fifo_1_if.slave  bus
);
  localparam int unsigned addr_w = $clog2(fifo_depth);
  localparam int unsigned ptr_w  = addr_w + 1;

  logic [data_width-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;
  logic [data_width-1:0] data_q;
  logic                  empty_c;
  logic                  full_c;
  logic                  rd_acc_c;
  logic                  wr_acc_c;

  // Pointer MSB is the wrap flag; equal addresses with differing wrap means full.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[addr_w-1:0] == rd_ptr[addr_w-1:0]) &&
                   (wr_ptr[addr_w] != rd_ptr[addr_w]);

  // A read frees a slot in the same edge, so a full FIFO still takes a write then.
  assign rd_acc_c = bus.cs && bus.rd_en && !empty_c;
  assign wr_acc_c = bus.cs && bus.wr_en && (!full_c || rd_acc_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_q <= '0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + ptr_w'(1);
      if (rd_acc_c) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
        data_q <= mem[rd_ptr[addr_w-1:0]];
      end
    end
  end

  // Storage is never cleared; reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc_c) mem[wr_ptr[addr_w-1:0]] <= bus.data_in;
  end

  assign bus.data_out = data_q;
  assign bus.empty    = empty_c;
  assign bus.full     = full_c;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.cs && bus.wr_en && !wr_acc_c) overflow_q  <= 1'b1;
      if (bus.cs && bus.rd_en && empty_c)   underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_1.sv
// Self-checking bench for fifo_1: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_fifo_1;
  localparam int unsigned depth = 8;
  localparam int unsigned dw    = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [dw-1:0] q[$];
  logic [dw-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_unf;

  fifo_1_if #(.data_width(dw)) bus ();

  fifo_1 #(.fifo_depth(depth), .data_width(dw)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [dw-1:0] got, input logic [dw-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, advance the model at posedge, compare after it.
  task automatic step(input logic rst, input logic c, input logic w, input logic r,
                      input logic [dw-1:0] d);
    bit rd_ok, wr_ok;
    @(negedge clk);
    rst_n       = rst;
    bus.cs      = c;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
    end else begin
      rd_ok = c && r && (q.size() > 0);
      wr_ok = c && w && ((q.size() < depth) || rd_ok);
      if (c && w && !wr_ok) exp_ovf = 1'b1;
      if (c && r && q.size() == 0) exp_unf = 1'b1;
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
    check("data_out", bus.data_out, exp_dout);
    check("empty", dw'(bus.empty), dw'(q.size() == 0));
    check("full", dw'(bus.full), dw'(q.size() == depth));
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", dw'(bus.overflow), dw'(exp_ovf));
    check("underflow", dw'(bus.underflow), dw'(exp_unf));
`endif
  endtask

  task automatic do_wr(input logic [dw-1:0] d); step(1'b1, 1'b1, 1'b1, 1'b0, d); endtask
  task automatic do_rd();                       step(1'b1, 1'b1, 1'b0, 1'b1, '0); endtask
  task automatic do_rst();                      step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF); endtask

  initial begin
    logic [dw-1:0] v;
    exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    rst_n = 1'b0; bus.cs = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;

    do_rst();
    check("rst_dout", bus.data_out, 32'd0);
    check("rst_empty", dw'(bus.empty), 32'd1);

    // Three writes, four reads: the last read hits empty and holds data_out.
    do_wr(32'd1); do_wr(32'd20); do_wr(32'd120);
    do_rd(); check("seq_rd0", bus.data_out, 32'd1);
    do_rd(); check("seq_rd1", bus.data_out, 32'd20);
    do_rd(); check("seq_rd2", bus.data_out, 32'd120);
    do_rd(); check("seq_rd3_hold", bus.data_out, 32'd120);
    check("seq_empty", dw'(bus.empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    check("seq_underflow", dw'(bus.underflow), 32'd1);
`endif
    do_rst();

    // Write-then-read pairs never fill the FIFO.
    for (int i = 0; i < 8; i++) begin
      v = 32'd1 << i;
      do_wr(v);
      do_rd();
      check("pair_rd", bus.data_out, v);
      check("pair_full", dw'(bus.full), 32'd0);
    end

    // Fill, drop a write on full, then drain.
    for (int i = 0; i < 8; i++) do_wr(32'd1 << i);
    check("fill_full", dw'(bus.full), 32'd1);
    do_wr(32'hDEAD);
    check("drop_full", dw'(bus.full), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    check("drop_overflow", dw'(bus.overflow), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      do_rd();
      v = 32'd1 << i;
      check("drain_rd", bus.data_out, v);
    end
    check("drain_empty", dw'(bus.empty), 32'd1);

    // Simultaneous read+write while full.
    do_rst();
    for (int i = 0; i < 8; i++) do_wr(32'd10 + 32'(i));
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h55);
    check("rw_full_rd", bus.data_out, 32'd10);
    check("rw_full_flag", dw'(bus.full), 32'd1);
    for (int i = 0; i < 8; i++) do_rd();
    check("rw_last", bus.data_out, 32'h55);
    check("rw_empty", dw'(bus.empty), 32'd1);

    // Chip select gating, then a reset mid-operation.
    do_wr(32'hA1); do_wr(32'hA2); do_wr(32'hA3);
    do_rd();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'hBAD);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hBAD);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hBAD);
    check("cs_hold_dout", bus.data_out, 32'hA1);
    check("cs_hold_empty", dw'(bus.empty), 32'd0);
    do_rst();
    check("mid_rst_empty", dw'(bus.empty), 32'd1);
    check("mid_rst_full", dw'(bus.full), 32'd0);
    check("mid_rst_dout", bus.data_out, 32'd0);
    do_rd();
    check("post_rst_rd", bus.data_out, 32'd0);

    // Random traffic with phases biased toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      int unsigned wp;
      wp = ((i / 200) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 99) < wp),
           ($urandom_range(0, 99) >= wp),
           $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
